// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the pipeline MEM stage owns the single-port memory by default,
// the debug unit gets idle-slot, forced (after a bounded wait) or locked burst access.
module dmem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pipe_addr,
    input  logic [31:0]       pipe_wdata,
    input  logic              pipe_re,
    input  logic              pipe_we,
    output logic [31:0]       pipe_rdata,
    output logic              pipe_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_ack,
    output logic [31:0]       dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic [CNT_W-1:0]  dbg_grant_cnt
);

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        ST_PIPE = 2'd0,
        ST_DBG  = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic [WAIT_W-1:0]  wait_nx_s;
    logic               dbg_ack_r;
    logic [31:0]        dbg_rdata_r;
    logic [CNT_W-1:0]   grant_cnt_r;

    logic               pipe_active_s;
    logic               dbg_pending_s;
    logic               dbg_access_s;
    logic               wait_full_s;
    logic [ADDR_W-1:0]  mem_addr_s;
    logic [31:0]        mem_wdata_s;
    logic               mem_we_s;
    logic               mem_re_s;
    logic [31:0]        pipe_rdata_s;
    logic               pipe_stall_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] res;
        if (val == {CNT_W{1'b1}}) begin
            res = val;
        end else begin
            res = val + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    assign pipe_active_s = pipe_re | pipe_we;
    // A request whose ack is showing this cycle must not be granted again.
    assign dbg_pending_s = dbg_req & ~dbg_ack_r;
    assign wait_full_s   = (wait_cnt_r == WAIT_W'(MAX_WAIT));

    // Next-state, wait counter and memory-port steering.
    always_comb begin
        state_nx_s   = state_r;
        wait_nx_s    = wait_cnt_r;
        dbg_access_s = 1'b0;
        mem_addr_s   = dbg_addr;
        mem_wdata_s  = dbg_wdata;
        mem_we_s     = 1'b0;
        mem_re_s     = 1'b0;
        pipe_rdata_s = 32'h0000_0000;
        pipe_stall_s = 1'b0;
        case (state_r)
            ST_PIPE: begin
                mem_addr_s  = pipe_addr[ADDR_W+1:2];
                mem_wdata_s = pipe_wdata;
                mem_we_s    = pipe_we;
                mem_re_s    = pipe_re;
                if (pipe_re) begin
                    pipe_rdata_s = mem_rdata;
                end else begin
                    pipe_rdata_s = 32'h0000_0000;
                end
                if (!dbg_pending_s) begin
                    wait_nx_s = {WAIT_W{1'b0}};
                end else if (!pipe_active_s || wait_full_s) begin
                    state_nx_s = ST_DBG;
                    wait_nx_s  = {WAIT_W{1'b0}};
                end else begin
                    wait_nx_s = wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DBG: begin
                pipe_stall_s = 1'b1;
                dbg_access_s = 1'b1;
                mem_we_s     = dbg_we;
                mem_re_s     = ~dbg_we;
                wait_nx_s    = {WAIT_W{1'b0}};
                if (dbg_lock) begin
                    state_nx_s = ST_LOCK;
                end else begin
                    state_nx_s = ST_PIPE;
                end
            end
            ST_LOCK: begin
                pipe_stall_s = 1'b1;
                wait_nx_s    = {WAIT_W{1'b0}};
                if (dbg_pending_s) begin
                    dbg_access_s = 1'b1;
                    mem_we_s     = dbg_we;
                    mem_re_s     = ~dbg_we;
                end else if (!dbg_lock) begin
                    state_nx_s = ST_PIPE;
                end else begin
                    state_nx_s = ST_LOCK;
                end
            end
            default: begin
                state_nx_s = ST_PIPE;
                wait_nx_s  = {WAIT_W{1'b0}};
            end
        endcase
    end

    // State, debug completion and grant counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_PIPE;
            wait_cnt_r  <= {WAIT_W{1'b0}};
            dbg_ack_r   <= 1'b0;
            dbg_rdata_r <= 32'h0000_0000;
            grant_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_nx_s;
            wait_cnt_r <= wait_nx_s;
            dbg_ack_r  <= dbg_access_s;
            if (dbg_access_s) begin
                grant_cnt_r <= sat_inc(grant_cnt_r);
                if (!dbg_we) begin
                    dbg_rdata_r <= mem_rdata;
                end
            end
        end
    end

    // Reset blocks any memory access in the reset cycle, aborting an in-flight debug write.
    assign mem_we        = mem_we_s & ~reset;
    assign mem_re        = mem_re_s & ~reset;
    assign mem_addr      = mem_addr_s;
    assign mem_wdata     = mem_wdata_s;
    assign pipe_rdata    = pipe_rdata_s;
    assign pipe_stall    = pipe_stall_s;
    assign dbg_ack       = dbg_ack_r;
    assign dbg_rdata     = dbg_rdata_r;
    assign dbg_grant_cnt = grant_cnt_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: per-cycle vector table plus lock-burst and
// counter-saturation sequences, with a behavioural 256-word memory.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] pipe_addr, pipe_wdata, pipe_rdata;
    logic        pipe_re, pipe_we, pipe_stall;
    logic        dbg_req, dbg_we, dbg_lock, dbg_ack;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_wdata, dbg_rdata;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_we, mem_re;
    logic [15:0] dbg_grant_cnt;

    // second instance with a narrow counter for the saturation check
    logic        s_req, s_ack;
    logic [31:0] s_rdata, s_prdata, s_wdata;
    logic        s_stall, s_we, s_re;
    logic [7:0]  s_maddr;
    logic [3:0]  s_cnt;

    logic [31:0] mem_model [0:255];

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.ADDR_W(8), .MAX_WAIT(4), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset),
        .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata), .pipe_re(pipe_re), .pipe_we(pipe_we),
        .pipe_rdata(pipe_rdata), .pipe_stall(pipe_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_lock(dbg_lock), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .dbg_grant_cnt(dbg_grant_cnt)
    );

    dmem_arbiter #(.ADDR_W(8), .MAX_WAIT(4), .CNT_W(4)) u_sat (
        .clk(clk), .reset(reset),
        .pipe_addr(32'h0000_0000), .pipe_wdata(32'h0000_0000), .pipe_re(1'b0), .pipe_we(1'b0),
        .pipe_rdata(s_prdata), .pipe_stall(s_stall),
        .dbg_req(s_req), .dbg_we(1'b0), .dbg_addr(8'h00), .dbg_wdata(32'h0000_0000),
        .dbg_lock(1'b0), .dbg_ack(s_ack), .dbg_rdata(s_rdata),
        .mem_addr(s_maddr), .mem_wdata(s_wdata), .mem_we(s_we), .mem_re(s_re),
        .mem_rdata(32'h0000_0000), .dbg_grant_cnt(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem_model[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem_model[mem_addr];

    typedef struct {
        logic        rst;
        logic [31:0] pa;
        logic [31:0] pwd;
        logic        pre;
        logic        pwe;
        logic        dreq;
        logic        dwe;
        logic [7:0]  dad;
        logic [31:0] dwd;
        logic        dlk;
        logic        e_stall;
        logic        e_mwe;
        logic        e_mre;
        logic [7:0]  e_maddr;
        logic [31:0] e_prd;
        logic        e_ack;
        logic [31:0] e_drd;
        logic [15:0] e_cnt;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        int cyc;
        logic got;
        logic [31:0] dn;

        //           rst   pa            pwd           pre   pwe   dreq  dwe   dad    dwd           dlk | stall mwe   mre   maddr  prd           ack   drd           cnt
        tbl[0]  = '{1'b1, 32'h0000_0000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 32'h0,        16'd0};
        tbl[1]  = '{1'b0, 32'h0000_0010, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 8'h04, 32'h0,        1'b0, 32'h0,        16'd0};
        tbl[2]  = '{1'b0, 32'h0000_0010, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 8'h04, 32'hDEADBEEF, 1'b0, 32'h0,        16'd0};
        tbl[3]  = '{1'b0, 32'h0000_0000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 8'h04, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 32'h0,        16'd0};
        tbl[4]  = '{1'b0, 32'h0000_0000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 8'h04, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 8'h04, 32'h0,        1'b0, 32'h0,        16'd0};
        tbl[5]  = '{1'b0, 32'h0000_0000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 8'h04, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0,        1'b1, 32'hDEADBEEF, 16'd1};
        for (int i = 6; i <= 10; i++) begin
            tbl[i] = '{1'b0, 32'h0000_0010, 32'h0,     1'b1, 1'b0, 1'b1, 1'b1, 8'h07, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b1, 8'h04, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 16'd1};
        end
        tbl[11] = '{1'b0, 32'h0000_0010, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 8'h07, 32'h12345678, 1'b0, 1'b1, 1'b1, 1'b0, 8'h07, 32'h0,        1'b0, 32'hDEADBEEF, 16'd1};
        tbl[12] = '{1'b0, 32'h0000_0010, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 8'h07, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b1, 8'h04, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 16'd2};
        tbl[13] = '{1'b0, 32'h0000_001C, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 8'h07, 32'h12345678, 1'b0, 32'hDEADBEEF, 16'd2};
        tbl[14] = '{1'b0, 32'h0000_0024, 32'h11111111, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 8'h09, 32'h0,        1'b0, 32'hDEADBEEF, 16'd2};
        tbl[15] = '{1'b0, 32'h0000_0000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 8'h09, 32'hAAAA5555, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 32'hDEADBEEF, 16'd2};
        tbl[16] = '{1'b1, 32'h0000_0000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 8'h09, 32'hAAAA5555, 1'b0, 1'b1, 1'b0, 1'b0, 8'h09, 32'h0,        1'b0, 32'hDEADBEEF, 16'd2};
        tbl[17] = '{1'b0, 32'h0000_0000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 32'h0,        16'd0};
        tbl[18] = '{1'b0, 32'h0000_0024, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 8'h09, 32'h11111111, 1'b0, 32'h0,        16'd0};
        tbl[19] = '{1'b0, 32'hFFFF_F410, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 8'h04, 32'hDEADBEEF, 1'b0, 32'h0,        16'd0};

        reset = 1'b1;
        pipe_addr = 32'h0; pipe_wdata = 32'h0; pipe_re = 1'b0; pipe_we = 1'b0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_wdata = 32'h0; dbg_lock = 1'b0;
        s_req = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) begin
            reset = tbl[i].rst;
            pipe_addr = tbl[i].pa; pipe_wdata = tbl[i].pwd;
            pipe_re = tbl[i].pre; pipe_we = tbl[i].pwe;
            dbg_req = tbl[i].dreq; dbg_we = tbl[i].dwe; dbg_addr = tbl[i].dad;
            dbg_wdata = tbl[i].dwd; dbg_lock = tbl[i].dlk;
            #3;
            chk($sformatf("v%0d.stall", i), {31'b0, pipe_stall}, {31'b0, tbl[i].e_stall});
            chk($sformatf("v%0d.mem_we", i), {31'b0, mem_we}, {31'b0, tbl[i].e_mwe});
            chk($sformatf("v%0d.mem_re", i), {31'b0, mem_re}, {31'b0, tbl[i].e_mre});
            chk($sformatf("v%0d.mem_addr", i), {24'b0, mem_addr}, {24'b0, tbl[i].e_maddr});
            chk($sformatf("v%0d.pipe_rdata", i), pipe_rdata, tbl[i].e_prd);
            chk($sformatf("v%0d.dbg_ack", i), {31'b0, dbg_ack}, {31'b0, tbl[i].e_ack});
            chk($sformatf("v%0d.dbg_rdata", i), dbg_rdata, tbl[i].e_drd);
            chk($sformatf("v%0d.grant_cnt", i), {16'b0, dbg_grant_cnt}, {16'b0, tbl[i].e_cnt});
            tick();
        end

        // lock burst: preload indices 0..7 and 15 through the pipeline
        reset = 1'b0;
        pipe_re = 1'b0; dbg_req = 1'b0;
        for (int i = 0; i < 9; i++) begin
            pipe_we = 1'b1;
            pipe_addr = (i == 8) ? 32'h0000_003C : 32'(i * 4);
            pipe_wdata = (i == 8) ? 32'h0F0F_0F0F : 32'hA000_0000 + 32'(i);
            #3;
            chk("preload.stall", {31'b0, pipe_stall}, 32'h0);
            tick();
        end
        pipe_we = 1'b0; pipe_addr = 32'h0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_lock = 1'b1;
        #3;
        chk("burst.decide_stall", {31'b0, pipe_stall}, 32'h0);
        tick();
        pipe_we = 1'b1; pipe_addr = 32'h0000_003C; pipe_wdata = 32'hFFFF_FFFF;
        k = 0;
        cyc = 0;
        while (k < 8 && cyc < 40) begin
            if (dbg_ack) begin
                chk($sformatf("burst.rdata%0d", k), dbg_rdata, 32'hA000_0000 + 32'(k));
                k++;
                if (k == 8) begin
                    dbg_req = 1'b0;
                    dbg_lock = 1'b0;
                end else begin
                    dbg_addr = 8'(k);
                end
            end
            #2;
            chk("burst.stall", {31'b0, pipe_stall}, 32'h1);
            chk("burst.mem_we", {31'b0, mem_we}, 32'h0);
            cyc++;
            if (k < 8) tick();
        end
        chk("burst.ack_count", 32'(k), 32'd8);
        tick();
        pipe_we = 1'b0; pipe_re = 1'b1; pipe_addr = 32'h0000_003C;
        #2;
        chk("burst.resume_stall", {31'b0, pipe_stall}, 32'h0);
        chk("burst.no_write", pipe_rdata, 32'h0F0F_0F0F);
        chk("burst.grant_cnt", {16'b0, dbg_grant_cnt}, 32'd8);
        tick();
        pipe_re = 1'b0;

        // narrow counter saturates at 15 without wrapping
        for (int i = 0; i < 20; i++) begin
            s_req = 1'b1;
            got = 1'b0;
            for (int c = 0; c < 8; c++) begin
                tick();
                if (s_ack) begin
                    got = 1'b1;
                    break;
                end
            end
            s_req = 1'b0;
            chk($sformatf("sat.ack%0d", i), {31'b0, got}, 32'h1);
            dn = (i + 1 > 15) ? 32'd15 : 32'(i + 1);
            chk($sformatf("sat.cnt%0d", i), {28'b0, s_cnt}, dn);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 256-word data memory between the pipeline MEM stage and the debug unit (memory dump/load over the debug link).
- The pipeline owns the memory by default. The debug unit gets single-cycle slots when the pipeline is idle, or forced slots after a bounded wait; during a forced slot the pipeline is stalled.
- A lock mode lets the debug unit hold the memory for burst dumps; the pipeline stays stalled for the whole lock.
- Sits between the MEM stage control/address/data signals and the data memory array. The hazard unit consumes `pipe_stall`.

Parameters:
- ADDR_W, 8, word-index width (256 words).
- MAX_WAIT, 4, maximum cycles a pending debug request waits behind active pipeline accesses before a forced grant.
- CNT_W, 16, width of the saturating debug-grant counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- pipe_addr  in  32  pipeline byte address (ALU result).
- pipe_wdata  in  32  pipeline store data.
- pipe_re  in  1  pipeline load.
- pipe_we  in  1  pipeline store.
- pipe_rdata  out  32  load data to WB path.
- pipe_stall  out  1  pipeline must freeze; its access this cycle is not performed.
- dbg_req  in  1  debug access request; held until dbg_ack.
- dbg_we  in  1  1=write, 0=read; stable while dbg_req.
- dbg_addr  in  ADDR_W  debug word index.
- dbg_wdata  in  32  debug write data.
- dbg_lock  in  1  debug holds memory across accesses.
- dbg_ack  out  1  one-cycle completion pulse.
- dbg_rdata  out  32  read data, valid with dbg_ack, held until next ack.
- mem_addr  out  ADDR_W  memory word index.
- mem_wdata  out  32  memory write data.
- mem_we  out  1  memory write enable (memory writes on posedge clk).
- mem_re  out  1  memory read enable.
- mem_rdata  in  32  memory asynchronous read data.
- dbg_grant_cnt  out  CNT_W  saturating count of debug accesses performed.

Behaviour:
- States: PIPE, DBG, LOCK. Reset (synchronous, active-high) forces:
  - state=PIPE, wait_cnt=0;
  - dbg_ack=0, dbg_rdata=0, dbg_grant_cnt=0;
  - mem_we=0 and mem_re=0 during the reset cycle.
- `pipe_active = pipe_re | pipe_we`.
- `dbg_pending = dbg_req & ~dbg_ack`. A request is never re-granted in its own ack cycle.
- PIPE state:
  - mem_addr=pipe_addr[ADDR_W+1:2]; upper address bits are ignored (wrap).
  - mem_wdata=pipe_wdata, mem_we=pipe_we, mem_re=pipe_re.
  - pipe_rdata=mem_rdata if pipe_re, else 0.
  - pipe_stall=0.
- PIPE->DBG at the clock edge when dbg_pending & (~pipe_active | wait_cnt==MAX_WAIT). The pipeline access in the deciding cycle completes normally.
- wait_cnt:
  - increments in PIPE while dbg_pending & pipe_active & wait_cnt<MAX_WAIT;
  - clears on entering DBG;
  - clears whenever dbg_pending=0.
- DBG state (exactly one cycle):
  - memory is driven only by the debug port: mem_addr=dbg_addr, mem_we=dbg_we, mem_re=~dbg_we, mem_wdata=dbg_wdata.
  - pipe_stall=1, pipe_rdata=0; pipeline writes are blocked.
  - At the edge: dbg_rdata<=mem_rdata (reads only), dbg_ack<=1, dbg_grant_cnt increments (saturates at all-ones).
  - Next state is LOCK if dbg_lock=1, else PIPE.
- LOCK state:
  - pipe_stall=1.
  - Each cycle with dbg_pending performs a debug access exactly as in DBG (ack next cycle, counter increments).
  - Cycles without dbg_pending drive mem_we=0 and mem_re=0.
  - LOCK->PIPE when dbg_lock=0 and no access is performed that cycle.
  - dbg_lock dropping during an access cycle: finish the access, exit at the next idle cycle.
- dbg_ack is a registered pulse, high for exactly one cycle per access. dbg_rdata is unchanged by write accesses.
- Latency:
  - Pipeline idle: req seen in cycle N, access in N+1, ack in N+2.
  - Fully contended: ack no later than N+MAX_WAIT+2.
- Reset during DBG or LOCK aborts the access: no ack, no write in the reset cycle, state returns to PIPE.

Test Plan:
- Pipeline store 0xDEADBEEF to byte address 0x10, then load 0x10 → mem_we in the store cycle at index 4; pipe_rdata=0xDEADBEEF; pipe_stall never asserted.
- Pipeline idle; debug read of index 4 at cycle N → DBG at N+1 (pipe_stall=1 for exactly one cycle); dbg_ack=1 at N+2 with dbg_rdata=0xDEADBEEF; dbg_grant_cnt=1.
- Pipeline loads every cycle; debug write of 0x12345678 to index 7 → forced grant after exactly MAX_WAIT=4 waiting cycles; ack at N+6; a later pipeline load of byte address 0x1C returns 0x12345678.
- dbg_lock=1 with 8 back-to-back reads of indices 0..7 → pipe_stall held continuously; 8 ack pulses; pipeline store attempted during the lock produces no mem_we; PIPE resumes one cycle after dbg_lock drops and the last access completes.
- Assert reset in the DBG cycle of a debug write → no mem_we, no dbg_ack; next cycle state=PIPE, pipe_stall=0, dbg_grant_cnt=0.
- Preload dbg_grant_cnt to near all-ones (CNT_W=4), perform 20 debug accesses → counter saturates at 15 and does not wrap.
